// File: rtl/hex_disp_pkg.sv
// hex_disp_pkg: segment table, blank pattern and scan state type shared by the hex scan controller
package hex_disp_pkg;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  typedef enum logic {BLANK, SHOW} scan_state_t;
  function automatic logic [6:0] seg_of(input logic [3:0] nib);
    return SEG_TABLE[nib];
  endfunction
endpackage

// File: rtl/hex_seg_decode.sv
// hex_seg_decode: nibble to active-low gfedcba segment pattern
module hex_seg_decode
  import hex_disp_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);
  assign seg_o = seg_of(nib_i);
endmodule

// File: rtl/hex_scan_ctrl.sv
// hex_scan_ctrl: tear-free multiplexed 7-segment scan controller; HEX_SCAN_BLINK_EN adds per-digit blinking
module hex_scan_ctrl
  import hex_disp_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500
`ifdef HEX_SCAN_BLINK_EN
  ,
  parameter int BLINK_FRAMES = 32
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [4*DIGITS-1:0]   load_data,
  input  logic [DIGITS-1:0]     load_mask,
`ifdef HEX_SCAN_BLINK_EN
  input  logic [DIGITS-1:0]     blink_mask,
`endif
  output logic [6:0]            seg_n,
  output logic [DIGITS-1:0]     dig_en_n,
  output logic                  frame_done
);
  localparam int MAXC = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int CW = $clog2(MAXC + 1);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic NO_BLANK = (BLANK_CYC == 0);
  localparam logic [CW-1:0] SHOW_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(NO_BLANK ? 0 : BLANK_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
  scan_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [4*DIGITS-1:0] act_word_q, pend_word_q;
  logic [DIGITS-1:0] act_mask_q, pend_mask_q, dig_en_q, dig_en_d;
  logic pend_full_q;
  logic [6:0] seg_q, seg_d, seg_dec;
  logic slot_end, boundary, accept, blink_off, lit;
  logic [3:0] nib;
  hex_seg_decode u_dec (.nib_i(nib), .seg_o(seg_dec));
`ifdef HEX_SCAN_BLINK_EN
  localparam int FW = $clog2(BLINK_FRAMES + 1);
  localparam logic [FW-1:0] F_LAST = FW'(BLINK_FRAMES - 1);
  logic [FW-1:0] fcnt_q;
  logic phase_q;
  assign blink_off = phase_q & blink_mask[idx_q];
  // Blink phase flips after every BLINK_FRAMES completed frames
  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt_q  <= '0;
      phase_q <= 1'b0;
    end else if (boundary) begin
      fcnt_q  <= (fcnt_q == F_LAST) ? '0 : fcnt_q + 1'b1;
      phase_q <= phase_q ^ (fcnt_q == F_LAST);
    end
  end
`else
  assign blink_off = 1'b0;
`endif
  // Slot sequencing and the per-cycle output pattern for the current slot
  always_comb begin
    slot_end = (state_q == SHOW) ? (cnt_q == SHOW_LAST) : (cnt_q == BLANK_LAST);
    state_d  = !slot_end ? state_q : ((state_q == SHOW && !NO_BLANK) ? BLANK : SHOW);
    cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
    idx_d    = (slot_end && state_q == SHOW) ? ((idx_q == IDX_LAST) ? '0 : idx_q + 1'b1) : idx_q;
    boundary = (state_q == SHOW) && slot_end && (idx_q == IDX_LAST);
    accept   = load_valid && !pend_full_q;
    nib      = act_word_q[{idx_q, 2'b00} +: 4];
    lit      = (state_q == SHOW) && act_mask_q[idx_q] && !blink_off;
    seg_d    = lit ? seg_dec : SEG_BLANK;
    dig_en_d = lit ? ~(DIGITS'(1) << idx_q) : '1;
  end
  // Scan state, pending/active word handoff at frame boundaries, registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= NO_BLANK ? SHOW : BLANK;
      cnt_q       <= '0;
      idx_q       <= '0;
      act_word_q  <= '0;
      act_mask_q  <= '0;
      pend_word_q <= '0;
      pend_mask_q <= '0;
      pend_full_q <= 1'b0;
      seg_q       <= SEG_BLANK;
      dig_en_q    <= '1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      pend_full_q <= accept | (pend_full_q & !boundary);
      seg_q       <= seg_d;
      dig_en_q    <= dig_en_d;
      if (boundary && pend_full_q) begin
        act_word_q <= pend_word_q;
        act_mask_q <= pend_mask_q;
      end
      if (accept) begin
        pend_word_q <= load_data;
        pend_mask_q <= load_mask;
      end
    end
  end
  assign load_ready = !pend_full_q;
  assign seg_n      = seg_q;
  assign dig_en_n   = dig_en_q;
  assign frame_done = boundary;
endmodule

// File: tb/tb_hex_scan_ctrl.sv
// tb_hex_scan_ctrl: directed checks of scan timing, decode, handshake, masking and mid-frame reset
module tb_hex_scan_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic load_valid = 1'b0;
  logic [15:0] load_data = '0;
  logic [3:0] load_mask = '0;
  logic [3:0] blink_mask = '0;
  logic load_ready, frame_done, load_ready2, frame_done2;
  logic [6:0] seg_n, seg_n2;
  logic [3:0] dig_en_n, dig_en_n2;
  int cyc = 0, n_cmp = 0, n_bad = 0, xfers = 0, last_xfer = -1;

  always #5 clk = ~clk;

  hex_scan_ctrl #(.DIGITS(4), .SCAN_DIV(4), .BLANK_CYC(2)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_mask(load_mask),
`ifdef HEX_SCAN_BLINK_EN
    .blink_mask(blink_mask),
`endif
    .seg_n(seg_n), .dig_en_n(dig_en_n), .frame_done(frame_done)
  );

  hex_scan_ctrl #(.DIGITS(4), .SCAN_DIV(4), .BLANK_CYC(0)) dut_nb (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready2),
    .load_data(load_data), .load_mask(load_mask),
`ifdef HEX_SCAN_BLINK_EN
    .blink_mask(blink_mask),
`endif
    .seg_n(seg_n2), .dig_en_n(dig_en_n2), .frame_done(frame_done2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic tick();
    logic will;
    will = load_valid & load_ready;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (will) begin
      load_valid = 1'b0;
      xfers++;
      last_xfer = cyc - 1;
    end
  endtask

  task automatic goto(input int c);
    while (cyc < c) tick();
  endtask

  task automatic offer(input logic [15:0] d, input logic [3:0] m);
    load_data = d;
    load_mask = m;
    load_valid = 1'b1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_seg"}, seg_n, 7'h7F);
    chk({tag, "_dig"}, dig_en_n, 4'hF);
    chk({tag, "_ready"}, load_ready, 1);
    chk({tag, "_fd"}, frame_done, 0);
  endtask

  task automatic check_frame(input int base, input logic [27:0] segs, input logic [3:0] mask);
    for (int k = 1; k <= 24; k++) begin
      int slot;
      logic lit;
      logic [3:0] ed;
      logic [6:0] es;
      slot = (k - 1) / 6;
      lit = ((k - 1) % 6 >= 2) && mask[slot];
      ed = lit ? ~(4'b0001 << slot) : 4'hF;
      es = lit ? segs[slot*7 +: 7] : 7'h7F;
      goto(base + k);
      chk("dig_en", dig_en_n, ed);
      chk("seg", seg_n, es);
      chk("frame_done", frame_done, k == 23);
    end
  endtask

  initial begin
    int b;
    repeat (3) tick();
    cyc = 0;
    chk_reset("rst");
    rst = 1'b0;
    offer(16'h12AF, 4'hF);
    tick();
    chk("xfer1", xfers, 1);
    chk("ready_full", load_ready, 0);
    offer(16'h8888, 4'b0101);
    check_frame(0, '0, 4'h0);
    goto(25);
    chk("xfer2_cyc", last_xfer, 24);
    chk("ready_refull", load_ready, 0);
    check_frame(24, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'hF);
    load_data = 16'hFFFF;
    load_mask = 4'hF;
    check_frame(48, '0, 4'b0101);
    chk("xfer_count", xfers, 2);
    offer(16'h3333, 4'hF);
    tick();
    chk("ready_pend3", load_ready, 0);
    goto(87);
    chk("dig2_lit", dig_en_n, 4'b1011);
    chk("dig2_seg", seg_n, 7'h00);
    rst = 1'b1;
    tick();
    chk_reset("midrst");
    rst = 1'b0;
    check_frame(88, '0, 4'h0);
    check_frame(112, '0, 4'h0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("nb_rst_fd", frame_done2, 0);
    chk("nb_rst_dig", dig_en_n2, 4'hF);
    b = cyc;
    offer(16'h12AF, 4'hF);
    for (int k = 0; k < 32; k++) begin
      goto(b + k);
      chk("nb_frame_done", frame_done2, k == 15 || k == 31);
      if (k == 20) begin
        chk("nb_dig0", dig_en_n2, 4'b1110);
        chk("nb_seg0", seg_n2, 7'h0E);
      end
      if (k == 21) begin
        chk("nb_dig1", dig_en_n2, 4'b1101);
        chk("nb_seg1", seg_n2, 7'h08);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
